frame_window_reader: RTL and testbench
======================================

// Module: frame_window_reader
// PURPOSE
//  Parametrised successor of the frame downloader. Reads a rectangular window of a stored
//  RGB565 frame from PSRAM in bursts and streams it as 17-bit tokens into the display queue.
//  Adds runtime window offset and size, vertical decimation, back-to-back queue writes and
//  abort. Sits between the PSRAM arbiter read port and the LCD-side pixel FIFO.
// PARAMETERS
//  ADDR_W       21   memory address width; 1 address = 1 pixel (16 bit)
//  BURST_WORDS  8    32-bit words per read request (2 pixels per word)
//  STRIDE       640  pixels per stored frame row
//  DIM_W        11   width of window/position fields and counters
// PORTS
//  clk            in   1       system clock
//  reset_n        in   1       synchronous reset, active low
//  start          in   1       1-cycle pulse: latch config, begin frame (ignored while busy)
//  abort          in   1       cancel current frame
//  base_addr      in   ADDR_W  frame base address
//  win_x, win_y   in   DIM_W   window origin in pixels (win_x must be even)
//  win_w, win_h   in   DIM_W   window size in output pixels/rows
//  row_step       in   2       source rows advanced per output row, 1..3 (0 treated as 1)
//  queue_full     in   1       downstream FIFO full
//  queue_data_o   out  17      token: {1,16'h0000} SOF, {1,16'h0001} SOL, {1,16'hFFFF} EOF, {0,pixel}
//  wr_en          out  1       queue write strobe
//  read_rq        out  1       read request to arbiter
//  read_addr      out  ADDR_W  burst start address
//  read_ack       in   1       arbiter grant
//  mem_rd_en      out  1       1-cycle read command pulse
//  read_data      in   32      burst data; pixel [15:0] precedes pixel [31:16]
//  rd_data_valid  in   1       read_data beat valid
//  busy           out  1       high from accepted start to DONE/abort
//  download_done  out  1       1-cycle pulse after EOF is written
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): all outputs 0, state IDLE, all counters 0.
//  States: IDLE -> LATCH -> SOF -> ROW_START -> REQ -> WAIT_ACK -> FILL -> DRAIN -> (REQ | ROW_END)
//    ROW_END -> (ROW_START | EOF) ; EOF -> DONE -> IDLE.
//  LATCH: register all config inputs. row_addr = base_addr + win_y*STRIDE + win_x.
//    Compute in a pipelined multiply. Width is ADDR_W+1; keep the low ADDR_W bits (wraps mod 2^ADDR_W).
//  SOF/ROW_START/EOF: emit the token with wr_en=1 in the first cycle where queue_full=0.
//    Otherwise hold. ROW_START sets col=0 and cur_addr=row_addr.
//  REQ: read_rq=1 and read_addr=cur_addr. Both stay stable until the burst completes.
//  WAIT_ACK: on read_ack, pulse mem_rd_en for exactly 1 cycle and go to FILL.
//  FILL: write each rd_data_valid beat into a 2*BURST_WORDS x 16 cache. Accept exactly
//    BURST_WORDS beats; extra beats are ignored. After the last beat, drop read_rq the next cycle.
//  DRAIN: n = min(2*BURST_WORDS, win_w-col) pixels.
//    Emit one pixel per cycle while queue_full=0. This is back-to-back: wr_en may stay high
//    on consecutive cycles.
//    While queue_full=1: wr_en=0 and the pixel index holds. The cache read must be
//    registered so that no pixel is lost or duplicated across a stall.
//    After n pixels: col+=n and cur_addr+=n. Go to REQ if col<win_w, else ROW_END.
//  ROW_END: row+=1 and row_addr+=row_step*STRIDE (mod 2^ADDR_W).
//    Go to EOF if row==win_h, else ROW_START.
//  DONE: download_done=1 for one cycle, busy=0, then IDLE.
//  win_w=0 or win_h=0: emit SOF then EOF only, with no memory reads; done pulses as normal.
//  start while busy: ignored. start and abort in the same cycle: abort wins, stay IDLE.
//  abort (any state): next cycle read_rq=0, wr_en=0, mem_rd_en=0, busy=0, state IDLE.
//    No EOF and no download_done. Late rd_data_valid beats are ignored in IDLE.
//  Reset mid-burst: same as reset; the arbiter is responsible for flushing its own burst.
//  Throughput: a full-width burst costs 2*BURST_WORDS drain cycles + ~4 cycles of overhead
//    plus arbiter latency.
// TESTING
//  1. Config base=0, win 0,0,480x272, step 1, queue never full.
//     -> SOF, then 272x(SOL + 480 pixels), then EOF.
//     -> Pixel k of row r equals mem[r*640+k]. done pulses once.
//  2. win_x=16, win_y=10, win_w=20, step 2.
//     -> Per row: burst addresses base+(10+2r)*640+16, then +16.
//     -> The second burst drains only 4 pixels.
//  3. Random queue_full toggling, 50% duty.
//     -> Token stream identical to the unstalled run. wr_en never high while queue_full=1.
//  4. win_h=0.
//     -> Exactly 2 tokens (1_0000h, 1_FFFFh), read_rq never rises, done pulses.
//  5. abort asserted during FILL.
//     -> Next cycle read_rq=0 and busy=0, no EOF. A new start then produces a clean frame.
//  6. base_addr=1F_FF00h, win_h=2.
//     -> The second row address wraps to (1F_FF00h+640) mod 2^21 = 00_0180h.

Source files
------------

// File: rtl/frame_window_reader.sv
// Frame window reader: streams a rectangular window of an RGB565 frame held in
// PSRAM into the display queue as 17-bit tokens (SOF / SOL / pixels / EOF).
// Each source row is fetched in bursts of BURST_WORDS 32-bit words. A burst is
// staged in a small cache and then drained one pixel per cycle.
module frame_window_reader #(
    parameter int ADDR_W      = 21,
    parameter int BURST_WORDS = 8,
    parameter int STRIDE      = 640,
    parameter int DIM_W       = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  win_x,
    input  logic [DIM_W-1:0]  win_y,
    input  logic [DIM_W-1:0]  win_w,
    input  logic [DIM_W-1:0]  win_h,
    input  logic [1:0]        row_step,
    input  logic              queue_full,
    output logic [16:0]       queue_data_o,
    output logic              wr_en,
    output logic              read_rq,
    output logic [ADDR_W-1:0] read_addr,
    input  logic              read_ack,
    output logic              mem_rd_en,
    input  logic [31:0]       read_data,
    input  logic              rd_data_valid,
    output logic              busy,
    output logic              download_done
);

    localparam int PIX  = 2 * BURST_WORDS;
    localparam int IW   = $clog2(PIX);          // cache index width
    localparam int BW   = $clog2(BURST_WORDS);  // beat counter width
    localparam logic [DIM_W-1:0] PIX_D = DIM_W'(PIX);

    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_SOF, S_ROW_START, S_REQ, S_WAIT_ACK,
        S_FILL, S_DRAIN, S_ROW_END, S_EOF, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              lat_q;
    logic [ADDR_W-1:0] base_q, row_addr_q, cur_addr_q;
    logic [DIM_W-1:0]  x_q, y_q, w_q, h_q, col_q, row_q;
    logic [1:0]        step_q;
    logic [ADDR_W:0]   prod_q;
    logic [BW-1:0]     beat_q;
    logic [IW-1:0]     idx_q;
    logic [15:0]       pix_q;
    logic              mem_rd_en_q;
    logic [15:0]       cache_q [PIX];

    logic [ADDR_W:0]   org_sum;
    logic [ADDR_W-1:0] row_inc;
    logic [1:0]        step_eff;
    logic [DIM_W-1:0]  rem, n_pix;
    logic              fill_last, drain_last;

    // Address arithmetic and per-burst drain length
    always_comb begin
        org_sum    = prod_q + {1'b0, base_q} + (ADDR_W+1)'(x_q);
        step_eff   = (step_q == 2'd0) ? 2'd1 : step_q;
        row_inc    = ADDR_W'(STRIDE * int'(step_eff));
        rem        = w_q - col_q;
        n_pix      = (rem > PIX_D) ? PIX_D : rem;
        fill_last  = rd_data_valid && (beat_q == BW'(BURST_WORDS - 1));
        drain_last = (DIM_W'(idx_q) == n_pix - DIM_W'(1));
    end

    // Next-state and output decode; abort overrides everything
    always_comb begin
        state_d       = state_q;
        wr_en         = 1'b0;
        read_rq       = 1'b0;
        busy          = 1'b1;
        download_done = 1'b0;
        queue_data_o  = 17'h0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_LATCH;
            end
            S_LATCH: if (lat_q) state_d = S_SOF;
            S_SOF: begin
                queue_data_o = 17'h1_0000;
                wr_en        = !queue_full;
                if (!queue_full)
                    state_d = (w_q == '0 || h_q == '0) ? S_EOF : S_ROW_START;
            end
            S_ROW_START: begin
                queue_data_o = 17'h1_0001;
                wr_en        = !queue_full;
                if (!queue_full) state_d = S_REQ;
            end
            S_REQ: begin
                read_rq = 1'b1;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                read_rq = 1'b1;
                if (read_ack) state_d = S_FILL;
            end
            S_FILL: begin
                read_rq = 1'b1;
                if (fill_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                queue_data_o = {1'b0, pix_q};
                wr_en        = !queue_full;
                if (!queue_full && drain_last)
                    state_d = ((col_q + n_pix) < w_q) ? S_REQ : S_ROW_END;
            end
            S_ROW_END: state_d = ((row_q + DIM_W'(1)) == h_q) ? S_EOF : S_ROW_START;
            S_EOF: begin
                queue_data_o = 17'h1_FFFF;
                wr_en        = !queue_full;
                if (!queue_full) state_d = S_DONE;
            end
            S_DONE: begin
                busy          = 1'b0;
                download_done = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    assign mem_rd_en = mem_rd_en_q;
    assign read_addr = cur_addr_q;

    // State, config, counters and the registered cache read port
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            lat_q       <= 1'b0;
            base_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            step_q      <= '0;
            prod_q      <= '0;
            row_addr_q  <= '0;
            cur_addr_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            beat_q      <= '0;
            idx_q       <= '0;
            pix_q       <= '0;
            mem_rd_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_rd_en_q <= (state_q == S_WAIT_ACK) && read_ack && !abort;
            case (state_q)
                S_IDLE: begin
                    // config captured together with the accepted start
                    if (start && !abort) begin
                        base_q <= base_addr;
                        x_q    <= win_x;
                        y_q    <= win_y;
                        w_q    <= win_w;
                        h_q    <= win_h;
                        step_q <= row_step;
                    end
                    lat_q <= 1'b0;
                    row_q <= '0;
                    col_q <= '0;
                end
                S_LATCH: begin
                    // two-stage origin: multiply first, then add base and x
                    lat_q  <= 1'b1;
                    prod_q <= (ADDR_W+1)'(int'(y_q) * STRIDE);
                    if (lat_q) row_addr_q <= org_sum[ADDR_W-1:0];
                end
                S_ROW_START: if (!queue_full) begin
                    col_q      <= '0;
                    cur_addr_q <= row_addr_q;
                end
                S_REQ: begin
                    beat_q <= '0;
                    idx_q  <= '0;
                end
                S_FILL: if (rd_data_valid) begin
                    beat_q <= beat_q + BW'(1);
                    if (beat_q == '0) pix_q <= read_data[15:0];
                end
                S_DRAIN: if (!queue_full) begin
                    idx_q <= idx_q + IW'(1);
                    pix_q <= cache_q[idx_q + IW'(1)];
                    if (drain_last) begin
                        col_q      <= col_q + n_pix;
                        cur_addr_q <= cur_addr_q + ADDR_W'(n_pix);
                    end
                end
                S_ROW_END: begin
                    row_q      <= row_q + DIM_W'(1);
                    row_addr_q <= row_addr_q + row_inc;
                end
                default: ;
            endcase
        end
    end

    // Burst staging: each accepted beat fills two consecutive pixel slots
    always_ff @(posedge clk) begin
        if (state_q == S_FILL && rd_data_valid) begin
            cache_q[{beat_q, 1'b0}] <= read_data[15:0];
            cache_q[{beat_q, 1'b1}] <= read_data[31:16];
        end
    end

endmodule

// File: tb/tb_frame_window_reader.sv
// Directed bench for frame_window_reader with a behavioural PSRAM arbiter.
module tb_frame_window_reader;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [20:0] base_addr = '0;
    logic [10:0] win_x = '0, win_y = '0, win_w = '0, win_h = '0;
    logic [1:0]  row_step = 2'd1;
    logic        queue_full = 1'b0;
    logic [16:0] queue_data_o;
    logic        wr_en, read_rq, mem_rd_en, busy, download_done;
    logic [20:0] read_addr;
    logic        read_ack = 1'b0, rd_data_valid = 1'b0;
    logic [31:0] read_data = '0;

    frame_window_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .win_x(win_x), .win_y(win_y), .win_w(win_w),
        .win_h(win_h), .row_step(row_step), .queue_full(queue_full),
        .queue_data_o(queue_data_o), .wr_en(wr_en), .read_rq(read_rq),
        .read_addr(read_addr), .read_ack(read_ack), .mem_rd_en(mem_rd_en),
        .read_data(read_data), .rd_data_valid(rd_data_valid), .busy(busy),
        .download_done(download_done)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [16:0] tok_q[$];
    logic [16:0] exp_q[$];
    logic [20:0] bur_q[$];
    int done_cnt = 0, viol = 0, rq_rise = 0;
    logic rq_prev = 1'b0;
    int tok_base, bur_base, done_base, rq_base;
    bit stall_en = 0;

    function automatic logic [15:0] pix(input logic [20:0] a);
        return a[15:0] ^ {a[20:16], a[20:10]};
    endfunction

    // Output monitor
    always @(negedge clk) begin
        if (wr_en) tok_q.push_back(queue_data_o);
        if (wr_en && queue_full) viol++;
        if (download_done) done_cnt++;
        if (mem_rd_en) bur_q.push_back(read_addr);
        if (read_rq && !rq_prev) rq_rise++;
        rq_prev = read_rq;
    end

    // Arbiter model: acks after a short delay, returns 9 beats (one surplus)
    int beats_left = 0, wait_n = 0;
    logic [20:0] baddr = '0;
    bit granted = 0;
    always @(negedge clk) begin
        read_ack = 1'b0;
        rd_data_valid = 1'b0;
        if (!reset_n) begin
            beats_left = 0;
            granted = 0;
        end else if (beats_left > 0) begin
            if ($urandom_range(0, 3) != 0) begin
                rd_data_valid = 1'b1;
                read_data = {pix(baddr + 21'd1), pix(baddr)};
                baddr = baddr + 21'd2;
                beats_left--;
            end
        end else if (mem_rd_en) begin
            beats_left = 9;
            baddr = read_addr;
        end else if (read_rq && !granted) begin
            if (wait_n >= 2) begin
                read_ack = 1'b1;
                granted = 1;
                wait_n = 0;
            end else wait_n++;
        end
        if (!read_rq) granted = 0;
    end

    // Downstream backpressure
    always @(posedge clk) begin
        #1;
        queue_full = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        tok_base = tok_q.size(); bur_base = bur_q.size();
        done_base = done_cnt; rq_base = rq_rise;
    endtask

    task automatic kick(input logic [20:0] b, input int x, y, w, h, st);
        base_addr = b; win_x = 11'(x); win_y = 11'(y);
        win_w = 11'(w); win_h = 11'(h); row_step = 2'(st);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        for (int i = 0; i < 6000 && done_cnt == done_base; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_done"}, 32'(done_cnt - done_base), 1);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic build_exp(input logic [20:0] b, input int x, y, w, h, st);
        int s;
        s = (st == 0) ? 1 : st;
        exp_q.delete();
        exp_q.push_back(17'h1_0000);
        if (w > 0 && h > 0)
            for (int r = 0; r < h; r++) begin
                exp_q.push_back(17'h1_0001);
                for (int k = 0; k < w; k++)
                    exp_q.push_back({1'b0, pix(b + 21'((y + r * s) * 640 + x + k))});
            end
        exp_q.push_back(17'h1_FFFF);
    endtask

    task automatic cmp_stream(input string tag);
        int got, bad;
        got = tok_q.size() - tok_base;
        bad = -1;
        chk({tag, "_len"}, 32'(got), 32'(exp_q.size()));
        for (int i = 0; i < got && i < exp_q.size(); i++)
            if (bad < 0 && tok_q[tok_base + i] !== exp_q[i]) bad = i;
        chk({tag, "_first_bad_idx"}, 32'(bad), 32'hFFFF_FFFF);
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_read_rq", 32'(read_rq), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 0);
        chk("rst_done", 32'(download_done), 0);
        chk("rst_qdata", 32'(queue_data_o), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: origin window, plus a start while busy that must be ignored
        mark();
        kick(21'h0, 0, 0, 48, 3, 1);
        chk("t1_busy", 32'(busy), 1);
        repeat (20) @(posedge clk);
        #1;
        base_addr = 21'h12345; win_w = 11'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_frame("t1");
        build_exp(21'h0, 0, 0, 48, 3, 1);
        cmp_stream("t1");
        chk("t1_bursts", 32'(bur_q.size() - bur_base), 9);

        // 2: offset window, row_step 2, partial second burst
        mark();
        kick(21'h0, 16, 10, 20, 3, 2);
        finish_frame("t2");
        build_exp(21'h0, 16, 10, 20, 3, 2);
        cmp_stream("t2");
        chk("t2_bursts", 32'(bur_q.size() - bur_base), 6);
        for (int r = 0; r < 3; r++) begin
            chk("t2_burst_a", 32'(bur_q[bur_base + 2*r]), 32'((10 + 2*r) * 640 + 16));
            chk("t2_burst_b", 32'(bur_q[bur_base + 2*r + 1]), 32'((10 + 2*r) * 640 + 32));
        end

        // 3: random backpressure, row_step 0 treated as 1
        mark();
        viol = 0;
        stall_en = 1;
        kick(21'h0_4000, 6, 3, 37, 3, 0);
        finish_frame("t3");
        stall_en = 0;
        @(posedge clk); #1;
        build_exp(21'h0_4000, 6, 3, 37, 3, 0);
        cmp_stream("t3");
        chk("t3_wr_while_full", 32'(viol), 0);

        // 4: empty windows
        mark();
        kick(21'h0, 0, 0, 8, 0, 1);
        finish_frame("t4h");
        build_exp(21'h0, 0, 0, 8, 0, 1);
        cmp_stream("t4h");
        chk("t4h_no_rq", 32'(rq_rise - rq_base), 0);
        mark();
        kick(21'h0, 0, 0, 0, 4, 1);
        finish_frame("t4w");
        build_exp(21'h0, 0, 0, 0, 4, 1);
        cmp_stream("t4w");
        chk("t4w_no_rq", 32'(rq_rise - rq_base), 0);

        // 5: abort during FILL, then a clean frame
        mark();
        kick(21'h0, 0, 0, 48, 3, 1);
        for (int i = 0; i < 200 && bur_q.size() == bur_base; i++) @(posedge clk);
        #1;
        chk("t5_reached_fill", 32'(bur_q.size() - bur_base), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t5_rq_off", 32'(read_rq), 0);
        chk("t5_busy_off", 32'(busy), 0);
        chk("t5_wr_off", 32'(wr_en), 0);
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_done", 32'(done_cnt - done_base), 0);
        chk("t5_no_eof", 32'(tok_q[tok_q.size() - 1] == 17'h1_FFFF), 0);
        mark();
        kick(21'h0_0800, 2, 1, 24, 2, 1);
        finish_frame("t5b");
        build_exp(21'h0_0800, 2, 1, 24, 2, 1);
        cmp_stream("t5b");

        // start and abort together: abort wins
        mark();
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("sa_no_tokens", 32'(tok_q.size() - tok_base), 0);

        // 6: row address wraps modulo 2^21
        mark();
        kick(21'h1F_FF00, 0, 0, 16, 2, 1);
        finish_frame("t6");
        build_exp(21'h1F_FF00, 0, 0, 16, 2, 1);
        cmp_stream("t6");
        chk("t6_bursts", 32'(bur_q.size() - bur_base), 2);
        chk("t6_row0", 32'(bur_q[bur_base]), 32'h1F_FF00);
        chk("t6_row1_wrap", 32'(bur_q[bur_base + 1]), 32'h00_0180);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
